stage_sequencer: RTL

//  Multicycle stage controller for the processor top. Replaces free-running stage clocks with one-cycle

---
 rtl/stage_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Multicycle stage controller: one-cycle IF/ID/EX/MEM/WB enables sequenced per instruction class.
// Optional performance counters are built only when PERF_COUNTERS_EN is defined.
module stage_sequencer #(
    parameter logic [4:0]  LW_FUNC     = 5'd2,
    parameter logic [4:0]  SW_FUNC     = 5'd3,
    parameter logic [4:0]  BEQ_FUNC    = 5'd4,
    parameter logic [4:0]  JAL_FUNC    = 5'd1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ins_type,
    input  logic [4:0]  func,
    input  logic        stop,
    input  logic        mem_ready,
    output logic        IF_en,
    output logic        ID_en,
    output logic        EX_en,
    output logic        MEM_en,
    output logic        WB_en,
    output logic [2:0]  state,
    output logic        busy,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] instr_count,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    localparam logic [1:0] TYPE_J = 2'b01;
    localparam logic [1:0] TYPE_I = 2'b10;

    state_t      state_reg;
    logic        if_en_reg, id_en_reg, ex_en_reg, mem_en_reg, wb_en_reg;
    logic        mem_err_reg;
    logic [1:0]  cls_type_reg;
    logic [4:0]  cls_func_reg;
    logic        cls_stop_reg;
    logic [7:0]  wait_reg;

    logic        retire;
    logic        halt_after;
    logic        mem_path;

    // Decide whether the current cycle ends the instruction. In ID the class is not yet
    // latched, so the live decode inputs are used for that one decision.
    always_comb begin
        retire     = 1'b0;
        halt_after = cls_stop_reg;
        case (state_reg)
            S_ID: begin
                retire     = (ins_type == TYPE_J) && (func != JAL_FUNC);
                halt_after = stop;
            end
            S_EX:    retire = (cls_type_reg == TYPE_J) ||
                              ((cls_type_reg == TYPE_I) && (cls_func_reg == BEQ_FUNC));
            S_MEM:   retire = mem_ready && (cls_func_reg != LW_FUNC);
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    assign mem_path = (cls_type_reg == TYPE_I) &&
                      ((cls_func_reg == LW_FUNC) || (cls_func_reg == SW_FUNC));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            if_en_reg    <= 1'b0;
            id_en_reg    <= 1'b0;
            ex_en_reg    <= 1'b0;
            mem_en_reg   <= 1'b0;
            wb_en_reg    <= 1'b0;
            mem_err_reg  <= 1'b0;
            cls_type_reg <= 2'b00;
            cls_func_reg <= 5'd0;
            cls_stop_reg <= 1'b0;
            wait_reg     <= 8'd0;
        end else begin
            if_en_reg  <= 1'b0;
            id_en_reg  <= 1'b0;
            ex_en_reg  <= 1'b0;
            mem_en_reg <= 1'b0;
            wb_en_reg  <= 1'b0;

            if (state_reg == S_ID) begin
                cls_type_reg <= ins_type;
                cls_func_reg <= func;
                cls_stop_reg <= stop;
            end

            if (retire) begin
                if (halt_after) begin
                    state_reg <= S_HALT;
                end else begin
                    state_reg <= S_IF;
                    if_en_reg <= 1'b1;
                end
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            state_reg <= S_IF;
                            if_en_reg <= 1'b1;
                        end
                    end
                    S_IF: begin
                        state_reg <= S_ID;
                        id_en_reg <= 1'b1;
                    end
                    S_ID: begin
                        state_reg <= S_EX;
                        ex_en_reg <= 1'b1;
                    end
                    S_EX: begin
                        if (mem_path) begin
                            state_reg  <= S_MEM;
                            mem_en_reg <= 1'b1;
                            wait_reg   <= 8'd0;
                        end else begin
                            state_reg <= S_WB;
                            wb_en_reg <= 1'b1;
                        end
                    end
                    S_MEM: begin
                        // Only a load reaches here with mem_ready high; a store retires above.
                        if (mem_ready) begin
                            state_reg <= S_WB;
                            wb_en_reg <= 1'b1;
                        end else if (wait_reg == 8'(MEM_TIMEOUT - 1)) begin
                            state_reg   <= S_ERR;
                            mem_err_reg <= 1'b1;
                        end else begin
                            wait_reg <= wait_reg + 8'd1;
                        end
                    end
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

    assign IF_en   = if_en_reg;
    assign ID_en   = id_en_reg;
    assign EX_en   = ex_en_reg;
    assign MEM_en  = mem_en_reg;
    assign WB_en   = wb_en_reg;
    assign state   = state_reg;
    assign busy    = (state_reg >= S_IF) && (state_reg <= S_WB);
    assign halted  = (state_reg == S_HALT);
    assign mem_err = mem_err_reg;

`ifdef PERF_COUNTERS_EN
    logic [15:0] instr_count_reg;
    logic [31:0] cycle_count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_count_reg <= 16'd0;
            cycle_count_reg <= 32'd0;
        end else begin
            if (retire) begin
                instr_count_reg <= instr_count_reg + 16'd1;
            end
            if (busy && (cycle_count_reg != 32'hFFFF_FFFF)) begin
                cycle_count_reg <= cycle_count_reg + 32'd1;
            end
        end
    end

    assign instr_count = instr_count_reg;
    assign cycle_count = cycle_count_reg;
`else
    assign instr_count = 16'd0;
    assign cycle_count = 32'd0;
`endif

endmodule
